// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect/stall/flush handling, IF/ID register.
// Define FETCH_SKID_EN to build a one-entry response skid buffer in front of the IF/ID register.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  output logic             IMemReqF,
  output logic [WIDTH-1:0] IMemAddrF,
  input  logic             IMemGntF,
  input  logic             IMemRspValidF,
  input  logic [31:0]      IMemRdataF,
  output logic             IMemRspReadyF,
  output logic [31:0]      InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [31:0]      NOP  = 32'h0000_0013;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] pc_f, pc_req_f;
  logic             req_fire, rsp_acc, rsp_fresh;
  logic             skid_full, wait_ready;
  logic             deliver;
  logic [31:0]      deliver_instr;
  logic [WIDTH-1:0] deliver_pc;

  assign req_fire  = IMemReqF & IMemGntF;
  assign rsp_acc   = IMemRspValidF & IMemRspReadyF;
  // A response accepted in WAIT belongs to pc_req_f unless a redirect kills it this cycle.
  assign rsp_fresh = (state == S_WAIT) & rsp_acc & ~PCSrcE;

`ifdef FETCH_SKID_EN
  logic             skid_valid;
  logic [31:0]      skid_instr;
  logic [WIDTH-1:0] skid_pc;
  logic             skid_park, skid_pop;

  assign skid_full  = skid_valid;
  assign wait_ready = 1'b1;
  assign skid_park  = rsp_fresh & StallD & ~FlushD;
  assign skid_pop   = skid_valid & ~StallD & ~FlushD & ~PCSrcE;

  // The skid only fills in WAIT and blocks new requests, so it and a fresh response never coexist.
  assign deliver       = skid_pop | (rsp_fresh & ~StallD & ~FlushD);
  assign deliver_instr = skid_valid ? skid_instr : IMemRdataF;
  assign deliver_pc    = skid_valid ? skid_pc : pc_req_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_instr <= NOP;
      skid_pc    <= '0;
    end else if (PCSrcE || FlushD) begin
      skid_valid <= 1'b0;
    end else if (skid_park) begin
      skid_valid <= 1'b1;
      skid_instr <= IMemRdataF;
      skid_pc    <= pc_req_f;
    end else if (skid_pop) begin
      skid_valid <= 1'b0;
    end
  end
`else
  assign skid_full     = 1'b0;
  // Back-pressure the memory while decode is stalled; it holds the response until accepted.
  assign wait_ready    = ~StallD;
  assign deliver       = rsp_fresh & ~StallD & ~FlushD;
  assign deliver_instr = IMemRdataF;
  assign deliver_pc    = pc_req_f;
`endif

  assign IMemReqF      = (state == S_REQ) & ~StallF & ~skid_full & ~rst;
  assign IMemAddrF     = pc_f;
  assign IMemRspReadyF = (state == S_WAIT) ? wait_ready : 1'b1;

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      // A request issued alongside a redirect fetches a dead address; its response must be dropped.
      S_REQ:     if (req_fire) state_nxt = PCSrcE ? S_DISCARD : S_WAIT;
      S_WAIT:    if (rsp_acc) state_nxt = S_REQ;
                 else if (PCSrcE) state_nxt = S_DISCARD;
      S_DISCARD: if (IMemRspValidF) state_nxt = S_REQ;
      default:   state_nxt = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc_f     <= RESET_PC;
      pc_req_f <= '0;
    end else begin
      state <= state_nxt;
      if (PCSrcE)        pc_f <= PCTargetE;
      else if (req_fire) pc_f <= pc_f + FOUR;
      if (req_fire)      pc_req_f <= pc_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (deliver) begin
        InstrD   <= deliver_instr;
        PCD      <= deliver_pc;
        PCPlus4D <= deliver_pc + FOUR;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-outstanding instruction memory model.
// Expectations adapt to FETCH_SKID_EN where skid behaviour changes the delivered stream.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallF, StallD, FlushD, IMemGntF, IMemRspValidF;
  logic [31:0] PCTargetE, IMemRdataF;
  logic        IMemReqF, IMemRspReadyF, ValidD;
  logic [31:0] IMemAddrF, InstrD, PCD, PCPlus4D;

  int checks = 0;
  int errors = 0;

  // Memory model state: a granted request is answered rsp_delay cycles later.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          rsp_delay;

  always #5 clk = ~clk;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .IMemReqF(IMemReqF), .IMemAddrF(IMemAddrF), .IMemGntF(IMemGntF),
    .IMemRspValidF(IMemRspValidF), .IMemRdataF(IMemRdataF), .IMemRspReadyF(IMemRspReadyF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Samples handshakes at the falling edge, then advances the memory model after the rising edge.
  task automatic tick();
    logic        fire, acc;
    logic [31:0] a;
    @(negedge clk);
    fire = IMemReqF & IMemGntF;
    acc  = IMemRspValidF & IMemRspReadyF;
    a    = IMemAddrF;
    @(posedge clk);
    #1;
    if (acc) IMemRspValidF = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = rsp_delay;
    end
    if (pend && !IMemRspValidF) begin
      if (pend_cnt == 0) begin
        IMemRspValidF = 1'b1;
        IMemRdataF    = word(pend_addr);
        pend          = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    IMemGntF = 1'b1; IMemRspValidF = 1'b0; IMemRdataF = '0;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0; rsp_delay = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (ValidD) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ValidD); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h want 0", PCD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4: got %h want 0", PCPlus4D); end
    checks++; if (IMemReqF !== 1'b1) begin errors++; $display("FAIL reset_req: got %0b want 1", IMemReqF); end
    checks++; if (IMemAddrF !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", IMemAddrF); end
  endtask

  task automatic test_fetch();
    logic [31:0] exp_pc;
    int          n;
    do_reset();
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (ValidD) begin
        exp_pc = 32'(n * 4);
        checks++; if (PCD !== exp_pc) begin errors++; $display("FAIL fetch_pcd%0d: got %h want %h", n, PCD, exp_pc); end
        checks++; if (InstrD !== word(exp_pc)) begin errors++; $display("FAIL fetch_instr%0d: got %h want %h", n, InstrD, word(exp_pc)); end
        checks++; if (PCPlus4D !== exp_pc + 32'd4) begin errors++; $display("FAIL fetch_pcplus4_%0d: got %h want %h", n, PCPlus4D, exp_pc + 32'd4); end
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL fetch_count: got %0d want 3", n); end
  endtask

  task automatic test_redirect();
    logic        seen_req, stale, done;
    logic [31:0] req_addr;
    do_reset();
    rsp_delay = 2;
    tick();
    checks++; if (IMemReqF !== 1'b0) begin errors++; $display("FAIL redir_wait_req: got %0b want 0", IMemReqF); end
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
    tick();
    PCSrcE = 1'b0;
    #1;
    checks++; if (IMemRspReadyF !== 1'b1) begin errors++; $display("FAIL redir_discard_ready: got %0b want 1", IMemRspReadyF); end
    seen_req = 1'b0; stale = 1'b0; done = 1'b0; req_addr = '0;
    for (int i = 0; i < 12 && !done; i++) begin
      tick();
      if (IMemReqF && !seen_req) begin
        seen_req = 1'b1;
        req_addr = IMemAddrF;
      end
      if (ValidD && PCD == 32'h0) stale = 1'b1;
      else if (ValidD) done = 1'b1;
    end
    checks++; if (req_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", req_addr); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL redir_stale_delivered: got %0b want 0", stale); end
    checks++; if (PCD !== 32'h100 || !done) begin errors++; $display("FAIL redir_pcd: got %h want 00000100", PCD); end
    checks++; if (InstrD !== word(32'h100)) begin errors++; $display("FAIL redir_instr: got %h want %h", InstrD, word(32'h100)); end
  endtask

  task automatic test_stall_d();
    logic        ok;
    logic [31:0] exp_pc;
    do_reset();
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL stall_first: ok %0b pcd %h want 1/0", ok, PCD); end
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PCD !== 32'h0 || InstrD !== word(32'h0) || ValidD !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got pcd %h instr %h valid %0b want 0/%h/1", i, PCD, InstrD, ValidD, word(32'h0));
      end
    end
    FlushD = 1'b1;
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", ValidD); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL flush_instr: got %h want %h", InstrD, NOP); end
    FlushD = 1'b0; StallD = 1'b0;
`ifdef FETCH_SKID_EN
    exp_pc = 32'h8;
`else
    exp_pc = 32'h4;
`endif
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1 || PCD !== exp_pc) begin errors++; $display("FAIL stall_resume_pcd: got %h want %h", PCD, exp_pc); end
  endtask

  task automatic test_stall_f();
    logic ok;
    do_reset();
    StallF = 1'b1;
    #1;
    checks++; if (IMemReqF !== 1'b0) begin errors++; $display("FAIL stallf_req: got %0b want 0", IMemReqF); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (IMemReqF !== 1'b0 || IMemAddrF !== 32'h0) begin errors++; $display("FAIL stallf_hold: req %0b addr %h want 0/0", IMemReqF, IMemAddrF); end
    StallF = 1'b0;
    #1;
    checks++; if (IMemReqF !== 1'b1 || IMemAddrF !== 32'h0) begin errors++; $display("FAIL stallf_release: req %0b addr %h want 1/0", IMemReqF, IMemAddrF); end
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL stallf_pcd: got %h want 0", PCD); end
  endtask

  task automatic test_redirect_stalled();
    logic ok;
    do_reset();
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
    tick();
    PCSrcE = 1'b0;
    #1;
    checks++; if (IMemReqF !== 1'b0 || IMemAddrF !== 32'h200) begin errors++; $display("FAIL redir_stall: req %0b addr %h want 0/00000200", IMemReqF, IMemAddrF); end
    StallF = 1'b0;
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1 || PCD !== 32'h200) begin errors++; $display("FAIL redir_stall_pcd: got %h want 00000200", PCD); end
  endtask

  task automatic test_reset_in_wait();
    logic ok, stale;
    do_reset();
    wait_valid(10, ok);
    rsp_delay = 3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; IMemGntF = 1'b0;
    #1;
    checks++; if (IMemReqF !== 1'b1 || IMemAddrF !== 32'h0) begin errors++; $display("FAIL rstwait_req: req %0b addr %h want 1/0", IMemReqF, IMemAddrF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rstwait_valid: got %0b want 0", ValidD); end
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ValidD) stale = 1'b1;
    end
    checks++; if (IMemRspValidF !== 1'b0 || stale !== 1'b0) begin errors++; $display("FAIL rstwait_drop: pending %0b delivered %0b want 0/0", IMemRspValidF, stale); end
    IMemGntF = 1'b1; rsp_delay = 0;
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL rstwait_pcd: got %h want 0", PCD); end
    checks++; if (InstrD !== word(32'h0)) begin errors++; $display("FAIL rstwait_instr: got %h want %h", InstrD, word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_redirect();
    test_stall_d();
    test_stall_f();
    test_redirect_stalled();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: PCSrcE  in  1  redirect request from execute; PCTargetE  in  WIDTH  redirect address.
REQ-006 SHALL have ports: StallF  in  1  block new fetch; StallD  in  1  hold IF/ID register; FlushD  in  1  bubble IF/ID register.
REQ-007 SHALL have ports: IMemReqF  out  1; IMemAddrF  out  WIDTH; IMemGntF  in  1  request accepted.
REQ-008 SHALL have ports: IMemRspValidF  in  1; IMemRdataF  in  32; IMemRspReadyF  out  1.
REQ-009 SHALL have ports: InstrD  out  32; PCD  out  WIDTH; PCPlus4D  out  WIDTH; ValidD  out  1  InstrD is a real instruction.

Function
REQ-010 SHALL keep at most one imem request outstanding; FSM states REQ, WAIT, DISCARD.
REQ-011 SHALL, in REQ, drive IMemReqF = ~StallF and IMemAddrF = PCF; on IMemReqF & IMemGntF, latch PCF into PCReqF, set PCF <= PCF+4 (mod 2^WIDTH), go WAIT.
REQ-012 SHALL, in WAIT, accept a response on IMemRspValidF & IMemRspReadyF, then go REQ.
REQ-013 SHALL, on accepted response with ~StallD & ~FlushD & ~PCSrcE, load InstrD <= IMemRdataF, PCD <= PCReqF, PCPlus4D <= PCReqF+4, ValidD <= 1 next edge (one-cycle response-to-decode latency).
REQ-014 SHALL hold InstrD/PCD/PCPlus4D/ValidD unchanged while StallD & ~FlushD.
REQ-015 SHALL, on FlushD (priority over StallD) or when no instruction is delivered and ~StallD, load InstrD <= 32'h0000_0013 (NOP), ValidD <= 0.
REQ-016 SHALL, on PCSrcE in any state, set PCF <= PCTargetE; overrides the +4 update in the same cycle.
REQ-017 SHALL, on PCSrcE in WAIT with no response accepted that cycle, go DISCARD; with response the same cycle, drop it and go REQ.
REQ-018 SHALL, in DISCARD, drive IMemRspReadyF = 1, drop the next response, then go REQ; further PCSrcE updates PCF, stays DISCARD.
REQ-019 SHALL, in REQ, drive IMemRspReadyF = 1 and drop any response (stale after reset).
REQ-020 SHALL treat PCSrcE & StallF simultaneously as redirect taken, no request issued.

Reset
REQ-021 SHALL on rst: state REQ, PCF = RESET_PC, PCReqF = 0, InstrD = NOP, PCD = 0, PCPlus4D = 0, ValidD = 0, skid empty.
REQ-022 SHALL on rst mid-transaction abandon the outstanding request; IMemReqF asserted for RESET_PC on the first cycle after rst deasserts (if ~StallF).

Configuration
REQ-023 SHALL compile a one-entry response skid buffer only when FETCH_SKID_EN is defined.
REQ-024 SHALL with FETCH_SKID_EN: IMemRspReadyF = 1 in WAIT; response arriving while StallD parks in skid, delivered when StallD drops; no new request while skid full; PCSrcE or FlushD empties skid.
REQ-025 SHALL without FETCH_SKID_EN: IMemRspReadyF = ~StallD in WAIT; memory holds response until accepted.

Verification
REQ-026 SHALL cover: rst, 0-wait memory, 3 fetches -> PCD 0x0,0x4,0x8 with ValidD=1, InstrD matches memory words.
REQ-027 SHALL cover: PCSrcE=1, PCTargetE=0x100 while WAIT -> next response dropped, next IMemAddrF=0x100, no ValidD for old PC.
REQ-028 SHALL cover: StallD 3 cycles during delivery -> InstrD/PCD held 3 cycles; FlushD during stall -> ValidD=0, InstrD=0x00000013.
REQ-029 SHALL cover: StallF=1 in REQ -> IMemReqF=0, PCF held; release -> request at held address.
REQ-030 SHALL cover: rst asserted in WAIT, stale response 2 cycles later -> dropped, first delivered PCD = RESET_PC; repeat with and without FETCH_SKID_EN.
